// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter: round-robin arbiter that lets NUM_TERM ATM terminals share one
// ledger RAM. Each granted terminal gets one atomic read-check-write transaction.
module atm_ledger_arbiter #(
  parameter int NUM_TERM = 4,
  parameter int AW       = 10,
  parameter int DW       = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_TERM-1:0]    req,
  input  logic [2*NUM_TERM-1:0]  op,
  input  logic [AW*NUM_TERM-1:0] acct,
  input  logic [AW*NUM_TERM-1:0] dest,
  input  logic [DW*NUM_TERM-1:0] amount,
  output logic [NUM_TERM-1:0]    gnt,
  output logic [NUM_TERM-1:0]    done,
  output logic                   ok,
  output logic [DW-1:0]          result_balance,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_we,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata
);

  localparam int PW = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_TRANSFER = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD_SRC, RD_DST, EVAL, WR_SRC, WR_DST, RESP
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       winner;
  logic                found;
  logic [1:0]          sel_op;
  logic [AW-1:0]       sel_acct, sel_dest;
  logic [DW-1:0]       sel_amt;

  logic [1:0]          op_q;
  logic [AW-1:0]       acct_q, dest_q;
  logic [DW-1:0]       amt_q;
  logic [DW-1:0]       src_bal, new_src, new_dst, result_q;
  logic                ok_q;
  logic [NUM_TERM-1:0] gnt_q;

  logic                eval_ok;
  logic [DW-1:0]       eval_src, eval_dst;
  logic [DW:0]         src_sum, dst_sum;

  // Round-robin search: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_TERM; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_TERM);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Pick out the winning terminal's request fields so they can be latched.
  always_comb begin
    sel_op   = '0;
    sel_acct = '0;
    sel_dest = '0;
    sel_amt  = '0;
    for (int i = 0; i < NUM_TERM; i++) begin
      if (winner == PW'(i)) begin
        sel_op   = op[2*i +: 2];
        sel_acct = acct[AW*i +: AW];
        sel_dest = dest[AW*i +: AW];
        sel_amt  = amount[DW*i +: DW];
      end
    end
  end

  // Balance check: sums are one bit wider so an overflow shows up instead of wrapping.
  always_comb begin
    src_sum  = {1'b0, src_bal} + {1'b0, amt_q};
    dst_sum  = {1'b0, mem_rdata} + {1'b0, amt_q};
    eval_ok  = 1'b1;
    eval_src = src_bal;
    eval_dst = mem_rdata;
    case (op_q)
      OP_READ: begin
        eval_ok = 1'b1;
      end
      OP_WITHDRAW: begin
        eval_ok  = (amt_q <= src_bal);
        eval_src = src_bal - amt_q;
      end
      OP_DEPOSIT: begin
        eval_ok  = !src_sum[DW];
        eval_src = src_sum[DW-1:0];
      end
      default: begin
        eval_ok  = (acct_q != dest_q) && (amt_q <= src_bal) && !dst_sum[DW];
        eval_src = src_bal - amt_q;
        eval_dst = dst_sum[DW-1:0];
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Every operation walks the same fixed sequence so latency is constant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = RD_SRC;
      RD_SRC:  state_d = RD_DST;
      RD_DST:  state_d = EVAL;
      EVAL:    state_d = WR_SRC;
      WR_SRC:  state_d = WR_DST;
      WR_DST:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction datapath: latch the request, capture balances, register the verdict.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      op_q     <= '0;
      acct_q   <= '0;
      dest_q   <= '0;
      amt_q    <= '0;
      src_bal  <= '0;
      new_src  <= '0;
      new_dst  <= '0;
      result_q <= '0;
      ok_q     <= 1'b0;
      gnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            op_q   <= sel_op;
            acct_q <= sel_acct;
            dest_q <= sel_dest;
            amt_q  <= sel_amt;
            gnt_q  <= NUM_TERM'(1) << winner;
            rr_ptr <= PW'((int'(winner) + 1) % NUM_TERM);
          end
        end
        RD_DST: src_bal <= mem_rdata;
        EVAL: begin
          ok_q     <= eval_ok;
          new_src  <= eval_src;
          new_dst  <= eval_dst;
          result_q <= eval_ok ? eval_src : src_bal;
        end
        RESP: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  // Ledger port: one access per cycle, writes only in the two write states.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      RD_SRC: mem_addr = acct_q;
      RD_DST: mem_addr = dest_q;
      WR_SRC: begin
        mem_addr  = acct_q;
        mem_we    = ok_q && (op_q != OP_READ);
        mem_wdata = new_src;
      end
      WR_DST: begin
        mem_addr  = dest_q;
        mem_we    = ok_q && (op_q == OP_TRANSFER);
        mem_wdata = new_dst;
      end
      default: ;
    endcase
  end

  assign gnt            = gnt_q;
  assign done           = (state_q == RESP) ? gnt_q : '0;
  assign ok             = ok_q;
  assign result_balance = result_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// tb_atm_ledger_arbiter: directed bench for atm_ledger_arbiter with a 1-cycle ledger RAM model.
module tb_atm_ledger_arbiter;

  localparam int NT = 4;
  localparam int AW = 10;
  localparam int DW = 10;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [NT-1:0]    req;
  logic [2*NT-1:0]  op;
  logic [AW*NT-1:0] acct;
  logic [AW*NT-1:0] dest;
  logic [DW*NT-1:0] amount;
  logic [NT-1:0]    gnt;
  logic [NT-1:0]    done;
  logic             ok;
  logic [DW-1:0]    result_balance;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  logic [DW-1:0]    ledger [0:1023];
  logic             preload;
  int               we_count = 0;
  int               gnt_bad  = 0;
  int               compared   = 0;
  int               mismatched = 0;

  atm_ledger_arbiter #(.NUM_TERM(NT), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op(op), .acct(acct), .dest(dest),
    .amount(amount), .gnt(gnt), .done(done), .ok(ok), .result_balance(result_balance),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Ledger RAM model: registered read, write on the same edge, preload of the starting balances.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ledger[i] <= '0;
      ledger[500] <= 10'd100;
      ledger[400] <= 10'd500;
      ledger[1000] <= 10'd0;
      ledger[300] <= 10'd100;
    end else begin
      mem_rdata <= ledger[mem_addr];
      if (mem_we) ledger[mem_addr] <= mem_wdata;
    end
  end

  // Count ledger write cycles.
  always @(posedge clock) begin
    if (mem_we) we_count++;
  end

  // Watch grant shape: never more than one grant, done only to the granted terminal.
  always @(negedge clock) begin
    if ($countones(gnt) > 1 || (done != '0 && done != gnt)) gnt_bad++;
  end

  // Overall time limit.
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_term(input int t, input logic [1:0] o, input logic [9:0] a,
                          input logic [9:0] d, input logic [9:0] m);
    op     = (op & ~(8'h03 << (2*t))) | ({6'b0, o} << (2*t));
    acct   = (acct & ~(40'h3FF << (10*t))) | ({30'b0, a} << (10*t));
    dest   = (dest & ~(40'h3FF << (10*t))) | ({30'b0, d} << (10*t));
    amount = (amount & ~(40'h3FF << (10*t))) | ({30'b0, m} << (10*t));
  endtask

  // Run one transaction from an IDLE cycle; returns latency, flags and number of writes.
  task automatic run_txn(input int t, input logic [1:0] o, input logic [9:0] a,
                         input logic [9:0] d, input logic [9:0] m,
                         output int lat, output logic got_ok, output logic [9:0] got_res,
                         output logic [3:0] got_gnt, output logic [3:0] got_done,
                         output int writes);
    int w0;
    set_term(t, o, a, d, m);
    req = req | (4'b0001 << t);
    w0 = we_count;
    @(posedge clock); #1;
    lat = 1;
    got_gnt = gnt;
    while (done == '0 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    got_ok = ok;
    got_res = result_balance;
    got_done = done;
    req = '0;
    @(posedge clock); #1;
    writes = we_count - w0;
  endtask

  task automatic test_reset();
    if (gnt !== 4'b0) begin $display("FAIL reset_gnt got=%b exp=0000", gnt); mismatched++; end compared++;
    if (done !== 4'b0) begin $display("FAIL reset_done got=%b exp=0000", done); mismatched++; end compared++;
    if (ok !== 1'b0) begin $display("FAIL reset_ok got=%b exp=0", ok); mismatched++; end compared++;
    if (result_balance !== 10'd0) begin $display("FAIL reset_result got=%0d exp=0", result_balance); mismatched++; end compared++;
    if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we got=%b exp=0", mem_we); mismatched++; end compared++;
    if (mem_addr !== 10'd0) begin $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); mismatched++; end compared++;
    if (mem_wdata !== 10'd0) begin $display("FAIL reset_mem_wdata got=%0d exp=0", mem_wdata); mismatched++; end compared++;
  endtask

  task automatic test_read();
    int lat, wr; logic k; logic [9:0] r; logic [3:0] g, dn;
    run_txn(0, 2'b00, 10'd500, 10'd0, 10'd0, lat, k, r, g, dn, wr);
    if (lat !== 6) begin $display("FAIL t0_latency got=%0d exp=6", lat); mismatched++; end compared++;
    if (g !== 4'b0001) begin $display("FAIL t0_gnt got=%b exp=0001", g); mismatched++; end compared++;
    if (dn !== 4'b0001) begin $display("FAIL t0_done got=%b exp=0001", dn); mismatched++; end compared++;
    if (k !== 1'b1) begin $display("FAIL t0_ok got=%b exp=1", k); mismatched++; end compared++;
    if (r !== 10'd100) begin $display("FAIL t0_result got=%0d exp=100", r); mismatched++; end compared++;
    if (wr !== 0) begin $display("FAIL t0_writes got=%0d exp=0", wr); mismatched++; end compared++;
  endtask

  task automatic test_withdraw();
    int lat, wr; logic k; logic [9:0] r; logic [3:0] g, dn;
    run_txn(1, 2'b01, 10'd500, 10'd0, 10'd100, lat, k, r, g, dn, wr);
    if (g !== 4'b0010) begin $display("FAIL t1_gnt got=%b exp=0010", g); mismatched++; end compared++;
    if (k !== 1'b1) begin $display("FAIL t1_ok got=%b exp=1", k); mismatched++; end compared++;
    if (r !== 10'd0) begin $display("FAIL t1_result got=%0d exp=0", r); mismatched++; end compared++;
    if (ledger[500] !== 10'd0) begin $display("FAIL t1_ledger500 got=%0d exp=0", ledger[500]); mismatched++; end compared++;
    if (wr !== 1) begin $display("FAIL t1_writes got=%0d exp=1", wr); mismatched++; end compared++;
    run_txn(1, 2'b01, 10'd500, 10'd0, 10'd1, lat, k, r, g, dn, wr);
    if (k !== 1'b0) begin $display("FAIL t1b_ok got=%b exp=0", k); mismatched++; end compared++;
    if (r !== 10'd0) begin $display("FAIL t1b_result got=%0d exp=0", r); mismatched++; end compared++;
    if (wr !== 0) begin $display("FAIL t1b_writes got=%0d exp=0", wr); mismatched++; end compared++;
  endtask

  task automatic test_transfer();
    int lat, wr; logic k; logic [9:0] r; logic [3:0] g, dn;
    run_txn(2, 2'b11, 10'd400, 10'd1000, 10'd90, lat, k, r, g, dn, wr);
    if (k !== 1'b1) begin $display("FAIL t2_ok got=%b exp=1", k); mismatched++; end compared++;
    if (r !== 10'd410) begin $display("FAIL t2_result got=%0d exp=410", r); mismatched++; end compared++;
    if (ledger[1000] !== 10'd90) begin $display("FAIL t2_ledger1000 got=%0d exp=90", ledger[1000]); mismatched++; end compared++;
    if (ledger[400] !== 10'd410) begin $display("FAIL t2_ledger400 got=%0d exp=410", ledger[400]); mismatched++; end compared++;
    if (wr !== 2) begin $display("FAIL t2_writes got=%0d exp=2", wr); mismatched++; end compared++;
    run_txn(2, 2'b11, 10'd400, 10'd400, 10'd90, lat, k, r, g, dn, wr);
    if (k !== 1'b0) begin $display("FAIL t2b_ok got=%b exp=0", k); mismatched++; end compared++;
    if (r !== 10'd410) begin $display("FAIL t2b_result got=%0d exp=410", r); mismatched++; end compared++;
    if (wr !== 0) begin $display("FAIL t2b_writes got=%0d exp=0", wr); mismatched++; end compared++;
  endtask

  task automatic test_zero_amount();
    int lat, wr; logic k; logic [9:0] r; logic [3:0] g, dn;
    run_txn(0, 2'b10, 10'd500, 10'd0, 10'd0, lat, k, r, g, dn, wr);
    if (k !== 1'b1) begin $display("FAIL zero_dep_ok got=%b exp=1", k); mismatched++; end compared++;
    if (wr !== 1) begin $display("FAIL zero_dep_writes got=%0d exp=1", wr); mismatched++; end compared++;
    run_txn(1, 2'b11, 10'd1000, 10'd1000, 10'd0, lat, k, r, g, dn, wr);
    if (k !== 1'b0) begin $display("FAIL zero_xfer_self_ok got=%b exp=0", k); mismatched++; end compared++;
    if (r !== 10'd90) begin $display("FAIL zero_xfer_self_result got=%0d exp=90", r); mismatched++; end compared++;
    if (wr !== 0) begin $display("FAIL zero_xfer_self_writes got=%0d exp=0", wr); mismatched++; end compared++;
  endtask

  task automatic test_deposit();
    int lat, wr; logic k; logic [9:0] r; logic [3:0] g, dn;
    run_txn(3, 2'b10, 10'd300, 10'd0, 10'd1000, lat, k, r, g, dn, wr);
    if (k !== 1'b0) begin $display("FAIL t3_ovf_ok got=%b exp=0", k); mismatched++; end compared++;
    if (r !== 10'd100) begin $display("FAIL t3_ovf_result got=%0d exp=100", r); mismatched++; end compared++;
    if (ledger[300] !== 10'd100) begin $display("FAIL t3_ovf_ledger got=%0d exp=100", ledger[300]); mismatched++; end compared++;
    if (wr !== 0) begin $display("FAIL t3_ovf_writes got=%0d exp=0", wr); mismatched++; end compared++;
    run_txn(3, 2'b10, 10'd300, 10'd0, 10'd923, lat, k, r, g, dn, wr);
    if (k !== 1'b1) begin $display("FAIL t3_max_ok got=%b exp=1", k); mismatched++; end compared++;
    if (r !== 10'd1023) begin $display("FAIL t3_max_result got=%0d exp=1023", r); mismatched++; end compared++;
    if (ledger[300] !== 10'd1023) begin $display("FAIL t3_max_ledger got=%0d exp=1023", ledger[300]); mismatched++; end compared++;
  endtask

  task automatic test_back_to_back();
    int cnt, cyc, last, bad0;
    logic [3:0] exp_done;
    logic [9:0] exp_res;
    set_term(0, 2'b00, 10'd500, 10'd0, 10'd0);
    set_term(1, 2'b00, 10'd400, 10'd0, 10'd0);
    set_term(2, 2'b00, 10'd1000, 10'd0, 10'd0);
    set_term(3, 2'b00, 10'd300, 10'd0, 10'd0);
    bad0 = gnt_bad;
    cnt = 0; cyc = 0; last = 0;
    req = 4'b1111;
    while (cnt < 5 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (done != '0) begin
        exp_done = 4'b0001 << (cnt % 4);
        case (cnt % 4)
          0: exp_res = 10'd0;
          1: exp_res = 10'd410;
          2: exp_res = 10'd90;
          default: exp_res = 10'd1023;
        endcase
        if (done !== exp_done) begin $display("FAIL t4_order[%0d] got=%b exp=%b", cnt, done, exp_done); mismatched++; end compared++;
        if (result_balance !== exp_res) begin $display("FAIL t4_result[%0d] got=%0d exp=%0d", cnt, result_balance, exp_res); mismatched++; end compared++;
        if (cnt == 0) begin
          if (cyc !== 6) begin $display("FAIL t4_first_done got=%0d exp=6", cyc); mismatched++; end compared++;
        end else begin
          if (cyc - last !== 7) begin $display("FAIL t4_spacing[%0d] got=%0d exp=7", cnt, cyc - last); mismatched++; end compared++;
        end
        last = cyc;
        cnt++;
        if (cnt == 5) req = '0;
      end
    end
    if (cnt !== 5) begin $display("FAIL t4_done_count got=%0d exp=5", cnt); mismatched++; end compared++;
    @(posedge clock); #1;
    @(posedge clock); #1;
    if (gnt !== 4'b0) begin $display("FAIL t4_idle_gnt got=%b exp=0000", gnt); mismatched++; end compared++;
    if (gnt_bad !== bad0) begin $display("FAIL t4_onehot got=%0d exp=%0d", gnt_bad, bad0); mismatched++; end compared++;
  endtask

  task automatic test_reset_abort();
    int n, lat, wr; logic k; logic [9:0] r; logic [3:0] g, dn;
    set_term(0, 2'b11, 10'd400, 10'd1000, 10'd10);
    req = 4'b0001;
    @(posedge clock); #1;
    n = 1;
    while (n < 5) begin @(posedge clock); #1; n++; end
    if (mem_we !== 1'b1 || mem_addr !== 10'd1000) begin $display("FAIL t5_in_wr_dst got=%b/%0d exp=1/1000", mem_we, mem_addr); mismatched++; end compared++;
    reset_n = 1'b0;
    #1;
    if (gnt !== 4'b0) begin $display("FAIL t5_gnt got=%b exp=0000", gnt); mismatched++; end compared++;
    if (done !== 4'b0) begin $display("FAIL t5_done got=%b exp=0000", done); mismatched++; end compared++;
    if (ok !== 1'b0) begin $display("FAIL t5_ok got=%b exp=0", ok); mismatched++; end compared++;
    if (result_balance !== 10'd0) begin $display("FAIL t5_result got=%0d exp=0", result_balance); mismatched++; end compared++;
    if (mem_we !== 1'b0) begin $display("FAIL t5_mem_we got=%b exp=0", mem_we); mismatched++; end compared++;
    if (mem_addr !== 10'd0) begin $display("FAIL t5_mem_addr got=%0d exp=0", mem_addr); mismatched++; end compared++;
    req = '0;
    @(posedge clock); #1;
    if (ledger[400] !== 10'd400) begin $display("FAIL t5_src_debited got=%0d exp=400", ledger[400]); mismatched++; end compared++;
    if (ledger[1000] !== 10'd90) begin $display("FAIL t5_dst_unchanged got=%0d exp=90", ledger[1000]); mismatched++; end compared++;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_txn(1, 2'b00, 10'd1000, 10'd0, 10'd0, lat, k, r, g, dn, wr);
    if (lat !== 6) begin $display("FAIL t5_post_latency got=%0d exp=6", lat); mismatched++; end compared++;
    if (k !== 1'b1) begin $display("FAIL t5_post_ok got=%b exp=1", k); mismatched++; end compared++;
    if (r !== 10'd90) begin $display("FAIL t5_post_result got=%0d exp=90", r); mismatched++; end compared++;
  endtask

  initial begin
    reset_n = 1'b0;
    preload = 1'b1;
    req = '0;
    op = '0;
    acct = '0;
    dest = '0;
    amount = '0;
    repeat (3) @(posedge clock);
    #1;
    preload = 1'b0;
    test_reset();
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_read();
    test_withdraw();
    test_transfer();
    test_zero_amount();
    test_deposit();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
